// File: rtl/i2c_cmd_sequencer.sv
// Queues AXI-side commands and hands them one at a time to an I2C byte master.
// Each command produces exactly one response (ACK, NACK, read data or timeout).
module i2c_cmd_sequencer #(
  parameter int AD_WIDTH    = 16,
  parameter int RD_WIDTH    = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [AD_WIDTH-1:0]    CMD_DATA,
  input  logic                   CMD_RNW,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  output logic [AD_WIDTH-1:0]    ADDR_DATA_OUT,
  output logic                   VALID_ADDR_DATA_OUT,
  output logic                   I2C_MASTER_TRIGGER,
  input  logic                   VALID_ADDR_DATA_OUT_ACK,
  input  logic                   VALID_ADDR_DATA_OUT_ACK_VALID,
  input  logic [RD_WIDTH-1:0]    RDATA_OUT,
  input  logic                   RDATA_VALID,
  output logic                   RDATA_VALID_ACK,
  output logic [RD_WIDTH-1:0]    RSP_DATA,
  output logic                   RSP_ERR,
  output logic                   RSP_TIMEOUT,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic                   BUSY_WR,
  output logic                   BUSY_RD,
  output logic [$clog2(DEPTH):0] FIFO_LEVEL
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE    = 3'd1;
  localparam logic [2:0] WAIT_ACK = 3'd2;
  localparam logic [2:0] WAIT_RD  = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [AD_WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [LW-1:0]       level;
  logic                push;
  logic                pop;
  logic [AD_WIDTH:0]   head;

  logic [2:0]          state;
  logic [AD_WIDTH-1:0] hold_data;
  logic                hold_rnw;
  logic [CW-1:0]       wait_cnt;
  logic                wait_expired;
  logic [RD_WIDTH-1:0] rsp_data_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  assign CMD_READY = (level < LW'(DEPTH)) && ARESETn;
  assign push      = CMD_VALID && CMD_READY;
  assign pop       = (state == IDLE) && (level != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= {CMD_RNW, CMD_DATA};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // The awaited event is tested before the timeout so it wins on the last wait cycle.
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= IDLE;
      hold_data     <= '0;
      hold_rnw      <= 1'b0;
      wait_cnt      <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold_data <= head[AD_WIDTH-1:0];
            hold_rnw  <= head[AD_WIDTH];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (VALID_ADDR_DATA_OUT_ACK_VALID) begin
            if (VALID_ADDR_DATA_OUT_ACK && hold_rnw) begin
              wait_cnt <= '0;
              state    <= WAIT_RD;
            end else begin
              rsp_data_q    <= '0;
              rsp_err_q     <= !VALID_ADDR_DATA_OUT_ACK;
              rsp_timeout_q <= 1'b0;
              state         <= RESP;
            end
          end else if (wait_expired) begin
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_RD: begin
          if (RDATA_VALID) begin
            rsp_data_q    <= RDATA_OUT;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state         <= RESP;
          end else if (wait_expired) begin
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ADDR_DATA_OUT       = hold_data;
  assign VALID_ADDR_DATA_OUT = (state == ISSUE) || (state == WAIT_ACK);
  assign I2C_MASTER_TRIGGER  = (state == ISSUE);
  assign RDATA_VALID_ACK     = (state == WAIT_RD) && RDATA_VALID;
  assign RSP_VALID           = (state == RESP);
  assign RSP_DATA            = rsp_data_q;
  assign RSP_ERR             = rsp_err_q;
  assign RSP_TIMEOUT         = rsp_timeout_q;
  assign BUSY_WR             = (state != IDLE) && !hold_rnw;
  assign BUSY_RD             = (state != IDLE) && hold_rnw;
  assign FIFO_LEVEL          = level;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Randomized bench for i2c_cmd_sequencer: plays the I2C master and AXI side and
// predicts every output from per-transaction timelines computed at issue time.
module tb_i2c_cmd_sequencer;
  localparam int AD_WIDTH    = 16;
  localparam int RD_WIDTH    = 8;
  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 20;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic                ACLK = 1'b0;
  logic                ARESETn;
  logic [AD_WIDTH-1:0] CMD_DATA;
  logic                CMD_RNW;
  logic                CMD_VALID;
  logic                CMD_READY;
  logic [AD_WIDTH-1:0] ADDR_DATA_OUT;
  logic                VALID_ADDR_DATA_OUT;
  logic                I2C_MASTER_TRIGGER;
  logic                VALID_ADDR_DATA_OUT_ACK;
  logic                VALID_ADDR_DATA_OUT_ACK_VALID;
  logic [RD_WIDTH-1:0] RDATA_OUT;
  logic                RDATA_VALID;
  logic                RDATA_VALID_ACK;
  logic [RD_WIDTH-1:0] RSP_DATA;
  logic                RSP_ERR;
  logic                RSP_TIMEOUT;
  logic                RSP_VALID;
  logic                RSP_READY;
  logic                BUSY_WR;
  logic                BUSY_RD;
  logic [LW-1:0]       FIFO_LEVEL;

  always #5 ACLK = ~ACLK;

  i2c_cmd_sequencer #(
    .AD_WIDTH(AD_WIDTH), .RD_WIDTH(RD_WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .CMD_DATA(CMD_DATA), .CMD_RNW(CMD_RNW), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .ADDR_DATA_OUT(ADDR_DATA_OUT), .VALID_ADDR_DATA_OUT(VALID_ADDR_DATA_OUT),
    .I2C_MASTER_TRIGGER(I2C_MASTER_TRIGGER),
    .VALID_ADDR_DATA_OUT_ACK(VALID_ADDR_DATA_OUT_ACK),
    .VALID_ADDR_DATA_OUT_ACK_VALID(VALID_ADDR_DATA_OUT_ACK_VALID),
    .RDATA_OUT(RDATA_OUT), .RDATA_VALID(RDATA_VALID), .RDATA_VALID_ACK(RDATA_VALID_ACK),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .BUSY_WR(BUSY_WR), .BUSY_RD(BUSY_RD), .FIFO_LEVEL(FIFO_LEVEL)
  );

  // ack_mode: 0 = ACK, 1 = NACK, 2 = silent master; rd_mode: 0 = data arrives, 1 = silent.
  typedef struct {
    int                  ack_mode;
    int                  a;
    int                  rd_mode;
    int                  r;
    logic [RD_WIDTH-1:0] rdata;
    int                  hold;
  } plan_t;

  plan_t               plan_q[$];
  logic [AD_WIDTH:0]   cmd_q[$];
  int                  level_m, cyc, push_left, push_pct;
  int                  check_count, pass_count;
  bit                  active, fixed_en, fixed_rnw;
  logic [AD_WIDTH-1:0] fixed_data;

  logic [AD_WIDTH-1:0] t_data;
  bit                  t_rnw, t_ack_val;
  int                  t_trig, t_ack_cyc, t_ack_end, t_rd_cyc, t_rd_end, t_rsp_start, t_hold;
  logic [RD_WIDTH-1:0] t_rdata, e_data;
  bit                  e_err, e_to;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic plan_t mkPlan(input int ack_mode, input int a, input int rd_mode,
                                   input int r, input logic [RD_WIDTH-1:0] rdata, input int hold);
    plan_t p;
    p.ack_mode = ack_mode;
    p.a        = a;
    p.rd_mode  = rd_mode;
    p.r        = r;
    p.rdata    = rdata;
    p.hold     = hold;
    return p;
  endfunction

  function automatic plan_t randomPlan();
    plan_t p;
    int    sel;
    sel        = int'($urandom_range(9));
    p.ack_mode = (sel < 6) ? 0 : ((sel < 8) ? 1 : 2);
    p.a        = ($urandom_range(9) == 0) ? TIMEOUT_CYC : int'($urandom_range(5, 1));
    p.rd_mode  = ($urandom_range(4) == 0) ? 1 : 0;
    p.r        = ($urandom_range(9) == 0) ? TIMEOUT_CYC : int'($urandom_range(5, 1));
    p.rdata    = RD_WIDTH'($urandom);
    p.hold     = int'($urandom_range(3));
    return p;
  endfunction

  function automatic bit inRd();
    return active && (t_rd_end >= 0) && (cyc > t_ack_end) && (cyc <= t_rd_end);
  endfunction

  // Lays out the whole timeline of the command issued at cycle t.
  task automatic startTxn(input int t);
    plan_t             p;
    logic [AD_WIDTH:0] cmd;
    if (plan_q.size() > 0) p = plan_q.pop_front();
    else p = randomPlan();
    cmd       = cmd_q.pop_front();
    t_rnw     = cmd[AD_WIDTH];
    t_data    = cmd[AD_WIDTH-1:0];
    t_trig    = t;
    t_rdata   = p.rdata;
    t_hold    = p.hold;
    t_ack_cyc = -1;
    t_rd_cyc  = -1;
    t_rd_end  = -1;
    t_ack_val = (p.ack_mode == 0);
    e_data    = '0;
    e_err     = 1'b0;
    e_to      = 1'b0;
    active    = 1'b1;
    if (p.ack_mode == 2) begin
      t_ack_end = t + TIMEOUT_CYC;
      e_err     = 1'b1;
      e_to      = 1'b1;
    end else begin
      t_ack_cyc = t + p.a;
      t_ack_end = t_ack_cyc;
      e_err     = (p.ack_mode == 1);
    end
    t_rsp_start = t_ack_end + 1;
    if (p.ack_mode == 0 && t_rnw) begin
      if (p.rd_mode == 0) begin
        t_rd_cyc = t_ack_end + p.r;
        t_rd_end = t_rd_cyc;
        e_data   = p.rdata;
      end else begin
        t_rd_end = t_ack_end + TIMEOUT_CYC;
        e_err    = 1'b1;
        e_to     = 1'b1;
      end
      t_rsp_start = t_rd_end + 1;
    end
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic applyStimulus();
    bit ack_win, rd_win, exp_rsp, exp_addr, accept, handshake;
    ack_win  = active && (cyc > t_trig) && (cyc <= t_ack_end);
    rd_win   = inRd();
    exp_rsp  = active && (cyc >= t_rsp_start);
    exp_addr = active && (cyc >= t_trig) && (cyc <= t_ack_end);

    if (push_left > 0) begin
      CMD_VALID = 1'b1;
      CMD_DATA  = fixed_en ? fixed_data : AD_WIDTH'($urandom);
      CMD_RNW   = fixed_en ? fixed_rnw : 1'($urandom);
    end else begin
      CMD_VALID = (int'($urandom_range(99)) < push_pct);
      CMD_DATA  = AD_WIDTH'($urandom);
      CMD_RNW   = 1'($urandom);
    end
    if (ack_win) begin
      VALID_ADDR_DATA_OUT_ACK_VALID = (cyc == t_ack_cyc);
      VALID_ADDR_DATA_OUT_ACK       = (cyc == t_ack_cyc) ? t_ack_val : 1'($urandom);
    end else begin
      VALID_ADDR_DATA_OUT_ACK_VALID = ($urandom_range(9) == 0);
      VALID_ADDR_DATA_OUT_ACK       = 1'($urandom);
    end
    if (rd_win) begin
      RDATA_VALID = (cyc == t_rd_cyc);
      RDATA_OUT   = (cyc == t_rd_cyc) ? t_rdata : RD_WIDTH'($urandom);
    end else begin
      RDATA_VALID = ($urandom_range(9) == 0);
      RDATA_OUT   = RD_WIDTH'($urandom);
    end
    RSP_READY = exp_rsp ? (cyc >= t_rsp_start + t_hold) : ($urandom_range(3) == 0);
    #1;

    checkOutput("fifo_level", 32'(FIFO_LEVEL), 32'(level_m));
    checkOutput("cmd_ready", 32'(CMD_READY), 32'(level_m < DEPTH));
    checkOutput("trigger", 32'(I2C_MASTER_TRIGGER), 32'(active && cyc == t_trig));
    checkOutput("addr_valid", 32'(VALID_ADDR_DATA_OUT), 32'(exp_addr));
    if (exp_addr) checkOutput("addr_data", 32'(ADDR_DATA_OUT), 32'(t_data));
    checkOutput("busy_wr", 32'(BUSY_WR), 32'(active && !t_rnw));
    checkOutput("busy_rd", 32'(BUSY_RD), 32'(active && t_rnw));
    checkOutput("rdata_ack", 32'(RDATA_VALID_ACK), 32'(active && cyc == t_rd_cyc));
    checkOutput("rsp_valid", 32'(RSP_VALID), 32'(exp_rsp));
    if (exp_rsp) begin
      checkOutput("rsp_data", 32'(RSP_DATA), 32'(e_data));
      checkOutput("rsp_err", 32'(RSP_ERR), 32'(e_err));
      checkOutput("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e_to));
    end

    accept    = CMD_VALID && (level_m < DEPTH);
    handshake = exp_rsp && RSP_READY;
    if (!active && level_m > 0) begin
      startTxn(cyc + 1);
      level_m--;
    end else if (handshake) begin
      active = 1'b0;
    end
    if (accept) begin
      cmd_q.push_back({CMD_RNW, CMD_DATA});
      level_m++;
      if (push_left > 0) push_left--;
    end
    @(posedge ACLK);
    #1;
    cyc++;
  endtask

  task automatic resetCheck();
    checkOutput("rst_cmd_ready", 32'(CMD_READY), 32'(0));
    checkOutput("rst_addr_data", 32'(ADDR_DATA_OUT), 32'(0));
    checkOutput("rst_addr_valid", 32'(VALID_ADDR_DATA_OUT), 32'(0));
    checkOutput("rst_trigger", 32'(I2C_MASTER_TRIGGER), 32'(0));
    checkOutput("rst_rdata_ack", 32'(RDATA_VALID_ACK), 32'(0));
    checkOutput("rst_rsp_data", 32'(RSP_DATA), 32'(0));
    checkOutput("rst_rsp_err", 32'(RSP_ERR), 32'(0));
    checkOutput("rst_rsp_timeout", 32'(RSP_TIMEOUT), 32'(0));
    checkOutput("rst_rsp_valid", 32'(RSP_VALID), 32'(0));
    checkOutput("rst_busy_wr", 32'(BUSY_WR), 32'(0));
    checkOutput("rst_busy_rd", 32'(BUSY_RD), 32'(0));
    checkOutput("rst_fifo_level", 32'(FIFO_LEVEL), 32'(0));
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((active || level_m > 0 || push_left > 0) && n < bound) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain", 32'(active || level_m > 0 || push_left > 0), 32'(0));
  endtask

  initial begin
    int n;
    check_count = 0;
    pass_count  = 0;
    cyc         = 0;
    active      = 1'b0;
    level_m     = 0;
    push_left   = 0;
    push_pct    = 0;
    fixed_en    = 1'b0;
    fixed_rnw   = 1'b0;
    fixed_data  = '0;
    ARESETn     = 1'b0;
    CMD_VALID   = 1'b1;
    CMD_DATA    = 16'h5555;
    CMD_RNW     = 1'b0;
    VALID_ADDR_DATA_OUT_ACK       = 1'b0;
    VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0;
    RDATA_OUT   = '0;
    RDATA_VALID = 1'b1;
    RSP_READY   = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    resetCheck();
    ARESETn = 1'b1;

    // Write 0x1234, ACK three cycles after the trigger.
    fixed_en   = 1'b1;
    fixed_data = 16'h1234;
    fixed_rnw  = 1'b0;
    push_left  = 1;
    plan_q.push_back(mkPlan(0, 3, 0, 1, 8'h00, 0));
    drain(200);

    // Read returning 0xA5.
    fixed_data = 16'h00A0;
    fixed_rnw  = 1'b1;
    push_left  = 1;
    plan_q.push_back(mkPlan(0, 2, 0, 2, 8'hA5, 1));
    drain(200);

    // Master stalls on the first command while more pushes fill the FIFO.
    fixed_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      plan_q.push_back(mkPlan(0, (i == 0) ? TIMEOUT_CYC : 2, 0, 1, RD_WIDTH'($urandom), 0));
    end
    push_left = 6;
    drain(600);

    // Silent master times out, then an ACK lands exactly on the timeout cycle.
    plan_q.push_back(mkPlan(2, 1, 0, 1, 8'h00, 0));
    plan_q.push_back(mkPlan(0, TIMEOUT_CYC, 0, TIMEOUT_CYC, 8'h3C, 0));
    push_left = 2;
    drain(300);

    // NACK on a read with the response held for 10 cycles.
    fixed_en   = 1'b1;
    fixed_data = 16'h0BEE;
    fixed_rnw  = 1'b1;
    push_left  = 1;
    plan_q.push_back(mkPlan(1, 2, 0, 1, 8'hFF, 10));
    drain(200);

    fixed_en = 1'b0;
    push_pct = 30;
    repeat (2500) applyStimulus();
    push_pct = 0;
    drain(800);

    // Reset in WAIT_RD with two commands still queued.
    fixed_en   = 1'b1;
    fixed_data = 16'h00C1;
    fixed_rnw  = 1'b1;
    plan_q.push_back(mkPlan(0, 1, 1, 1, 8'h00, 0));
    push_left = 3;
    n = 0;
    while (!(inRd() && level_m >= 2) && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("reach_wait_rd", 32'(inRd() && level_m >= 2), 32'(1));
    ARESETn   = 1'b0;
    CMD_VALID = 1'b1;
    #1;
    resetCheck();
    @(posedge ACLK);
    #1;
    resetCheck();
    cmd_q.delete();
    plan_q.delete();
    level_m   = 0;
    active    = 1'b0;
    ARESETn   = 1'b1;
    fixed_en  = 1'b0;
    push_left = 1;
    drain(200);
    repeat (10) applyStimulus();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameters, each SHALL be name, default, meaning:
 - AD_WIDTH, 16, width of the command word sent to the I2C master.
 - RD_WIDTH, 8, width of the read data.
 - DEPTH, 4, command FIFO entries (power of 2, >=2).
 - TIMEOUT_CYC, 1023, maximum wait cycles per handshake phase.
REQ-002 Ports SHALL be name, direction, width, meaning:
 - ACLK in 1: single clock, rising edge.
 - ARESETn in 1: reset, asynchronous, active-low.
 - CMD_DATA in AD_WIDTH: command word from the AXI slave.
 - CMD_RNW in 1: 1 = read command, 0 = write command.
 - CMD_VALID in 1 / CMD_READY out 1: push handshake.
 - ADDR_DATA_OUT out AD_WIDTH: word to the I2C master.
 - VALID_ADDR_DATA_OUT out 1: word valid.
 - I2C_MASTER_TRIGGER out 1: start pulse to the master.
 - VALID_ADDR_DATA_OUT_ACK in 1: 1 = slave ACK, 0 = NACK.
 - VALID_ADDR_DATA_OUT_ACK_VALID in 1: qualifies the ACK.
 - RDATA_OUT in RD_WIDTH / RDATA_VALID in 1: read data from the master.
 - RDATA_VALID_ACK out 1: read data consumed.
 - RSP_DATA out RD_WIDTH, RSP_ERR out 1, RSP_TIMEOUT out 1, RSP_VALID out 1, RSP_READY in 1: response to the AXI slave.
 - BUSY_WR out 1, BUSY_RD out 1: a write or read is in flight.
 - FIFO_LEVEL out $clog2(DEPTH)+1: FIFO occupancy.
REQ-003 Reset SHALL be one clock ACLK and asynchronous active-low ARESETn; there SHALL be no other clock or reset.

Function
REQ-004 The FIFO SHALL store {CMD_RNW, CMD_DATA} and push when CMD_VALID and CMD_READY are both high.
REQ-005 CMD_READY SHALL equal (FIFO_LEVEL < DEPTH) AND ARESETn; a push is refused while full, even if a pop occurs in the same cycle.
REQ-006 The FIFO pointers SHALL wrap modulo DEPTH; FIFO_LEVEL SHALL increment on push and decrement on pop, and SHALL be unchanged on a simultaneous push and pop.
REQ-007 The FSM states SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_RD and RESP, with at most one command outstanding.
REQ-008 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head into a hold register and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-009 ISSUE (exactly 1 cycle): I2C_MASTER_TRIGGER=1 and VALID_ADDR_DATA_OUT=1, then go to WAIT_ACK.
REQ-010 Latency: a push into an empty FIFO in IDLE at cycle N SHALL put the FSM in IDLE with data available at N+1 and in ISSUE at N+2 (trigger high).
REQ-011 ADDR_DATA_OUT SHALL be driven from the hold register and stay stable from ISSUE through WAIT_ACK; VALID_ADDR_DATA_OUT SHALL be high in ISSUE and WAIT_ACK, and low otherwise.
REQ-012 WAIT_ACK, on ACK_VALID=1:
 - ACK=1 and write: go to RESP with ERR=0 and DATA=0.
 - ACK=1 and read: go to WAIT_RD.
 - ACK=0: go to RESP with ERR=1 and DATA=0.
REQ-013 WAIT_RD: on RDATA_VALID=1 the FSM SHALL capture RDATA_OUT into RSP_DATA, pulse RDATA_VALID_ACK for exactly 1 cycle, and go to RESP with ERR=0.
REQ-014 A timeout counter SHALL clear on entry to WAIT_ACK and WAIT_RD; if it reaches TIMEOUT_CYC without the awaited event, the FSM SHALL go to RESP with RSP_ERR=1 and RSP_TIMEOUT=1.
REQ-015 An awaited event arriving in the same cycle as the timeout SHALL win over the timeout.
REQ-016 ACK_VALID outside WAIT_ACK and RDATA_VALID outside WAIT_RD SHALL be ignored, with no RDATA_VALID_ACK and no state change.
REQ-017 RESP: RSP_VALID=1 and RSP_DATA, RSP_ERR and RSP_TIMEOUT SHALL hold stable until RSP_READY=1; the FSM SHALL then go to IDLE, and RSP_VALID SHALL drop next cycle.
REQ-018 Responses SHALL be returned in command order, one per command.
REQ-019 BUSY_WR or BUSY_RD (per the held CMD_RNW) SHALL be high in every state other than IDLE; they SHALL never be high together.
REQ-020 FIFO pushes SHALL continue in every FSM state.

Reset
REQ-021 While ARESETn=0, all outputs SHALL be 0, the FIFO SHALL be empty, the FSM SHALL be in IDLE and the counters SHALL be 0.
REQ-022 Reset asserted mid-transaction SHALL abort the transaction with no response and discard FIFO contents.
REQ-023 The first push SHALL be accepted on the first rising ACLK edge after ARESETn goes high.

Verification
REQ-024 Write 0x1234 pushed, ACK_VALID=1 with ACK=1 three cycles after trigger -> trigger one pulse, ADDR_DATA_OUT=0x1234, RSP_VALID with ERR=0, BUSY_WR high throughout.
REQ-025 Read pushed, ACK=1, then RDATA_OUT=0xA5 with RDATA_VALID -> RDATA_VALID_ACK one pulse, RSP_DATA=0xA5, ERR=0.
REQ-026 Five pushes with DEPTH=4 while the master stalls -> CMD_READY low after 4, FIFO_LEVEL=4; responses return in order once acks arrive.
REQ-027 Command with no ACK_VALID -> RSP after TIMEOUT_CYC cycles with ERR=1 and TIMEOUT=1; ACK on the timeout cycle -> normal response.
REQ-028 NACK on a read -> RSP ERR=1, TIMEOUT=0, no WAIT_RD; RSP_READY held low 10 cycles -> RSP outputs stable throughout.
REQ-029 ARESETn pulsed low in WAIT_RD with 2 queued commands -> all outputs 0, FIFO_LEVEL=0, no response emitted.
